// File: rtl/ws2812b_pkg.sv
// Shared types and constants for the ws2812b frame streamer slice.
// Also holds the channel scaling helper used when WS2812B_BRIGHTNESS_EN is defined.
package ws2812b_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PRESENT
    } state_t;

    localparam int PIXEL_W = 24;
    localparam int CHAN_W  = 8;

    localparam int G_HI = 23;
    localparam int G_LO = 16;
    localparam int R_HI = 15;
    localparam int R_LO = 8;
    localparam int B_HI = 7;
    localparam int B_LO = 0;

    // (c * (b + 1)) >> 8: b=255 is identity, b=0 blanks the channel
    function automatic logic [CHAN_W-1:0] scale_chan(input logic [CHAN_W-1:0] c,
                                                     input logic [CHAN_W-1:0] b);
        logic [15:0] prod;
        prod = {8'd0, c} * ({8'd0, b} + 16'd1);
        return prod[15:8];
    endfunction

    function automatic logic [PIXEL_W-1:0] scale_pixel(input logic [PIXEL_W-1:0] px,
                                                       input logic [CHAN_W-1:0]  b);
        return {scale_chan(px[G_HI:G_LO], b),
                scale_chan(px[R_HI:R_LO], b),
                scale_chan(px[B_HI:B_LO], b)};
    endfunction

endpackage

// File: rtl/ws2812b_pixel_ram.sv
// Simple dual-port pixel RAM: one synchronous write port, one synchronous read port.
// Same-address read/write in one cycle returns the old word; contents survive reset.
module ws2812b_pixel_ram
    import ws2812b_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [PIXEL_W-1:0] wr_data,
    input  logic               rd_en,
    input  logic [AW-1:0]      rd_addr,
    output logic [PIXEL_W-1:0] rd_data
);

    logic [PIXEL_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Only the read register is reset so the streamer presents zero after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ws2812b_frame_streamer.sv
// Pixel frame buffer and sequencer feeding the ws2812b bit serializer.
// Optional global brightness scaling is enabled by defining WS2812B_BRIGHTNESS_EN.
module ws2812b_frame_streamer
    import ws2812b_pkg::*;
#(
    parameter  int NUM_LEDS = 16,
    localparam int ADDR_W   = $clog2(NUM_LEDS),
    localparam int LEN_W    = ADDR_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [PIXEL_W-1:0] wr_data,
    input  logic               start,
    input  logic [LEN_W-1:0]   len,
`ifdef WS2812B_BRIGHTNESS_EN
    input  logic [CHAN_W-1:0]  brightness,
`endif
    output logic               busy,
    output logic               done,
    output logic [PIXEL_W-1:0] pix_data,
    output logic               pix_valid,
    output logic               pix_latch,
    input  logic               pix_ready
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   index_q, index_d;
    logic [LEN_W-1:0]    count_q, count_d;
    logic                done_q, done_d;
    logic                last_pix;
    logic                ram_we;
    logic                ram_re;
    logic [PIXEL_W-1:0]  ram_q;

    assign ram_we   = wr_en && ({1'b0, wr_addr} < LEN_W'(NUM_LEDS));
    assign ram_re   = (state_q == FETCH);
    assign last_pix = ({1'b0, index_q} == (count_q - LEN_W'(1)));

    ws2812b_pixel_ram #(
        .DEPTH (NUM_LEDS),
        .AW    (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (ram_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (ram_re),
        .rd_addr (index_q),
        .rd_data (ram_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            index_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        count_d = count_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        count_d = (len > LEN_W'(NUM_LEDS)) ? LEN_W'(NUM_LEDS) : len;
                        index_d = '0;
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                state_d = PRESENT;
            end
            PRESENT: begin
                if (pix_ready) begin
                    if (last_pix) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        index_d = index_q + ADDR_W'(1);
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign pix_valid = (state_q == PRESENT);
    assign pix_latch = pix_valid && last_pix;

`ifdef WS2812B_BRIGHTNESS_EN
    // Brightness is captured alongside the RAM read so the presented word stays stable
    logic [CHAN_W-1:0] brt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            brt_q <= '1;
        end else if (state_q == FETCH) begin
            brt_q <= brightness;
        end
    end

    assign pix_data = scale_pixel(ram_q, brt_q);
`else
    assign pix_data = ram_q;
`endif

endmodule

// File: tb/tb_ws2812b_frame_streamer.sv
// Self-checking bench for ws2812b_frame_streamer against a frame-level reference model.
// Define WS2812B_BRIGHTNESS_EN to also exercise brightness scaling.
module tb_ws2812b_frame_streamer;

    localparam int N  = 16;
    localparam int N2 = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [23:0] wr_data;
    logic        start;
    logic [4:0]  len;
    logic [7:0]  brightness;
    logic        busy, done, pix_valid, pix_latch, pix_ready;
    logic [23:0] pix_data;

    logic        b_wr_en;
    logic [3:0]  b_wr_addr;
    logic [23:0] b_wr_data;
    logic        b_start;
    logic [4:0]  b_len;
    logic        b_busy, b_done, b_pix_valid, b_pix_latch, b_pix_ready;
    logic [23:0] b_pix_data;

    always #5 clk = ~clk;

    ws2812b_frame_streamer #(.NUM_LEDS(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .len        (len),
`ifdef WS2812B_BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .busy       (busy),
        .done       (done),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_latch  (pix_latch),
        .pix_ready  (pix_ready)
    );

    ws2812b_frame_streamer #(.NUM_LEDS(N2)) dut12 (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (b_wr_en),
        .wr_addr    (b_wr_addr),
        .wr_data    (b_wr_data),
        .start      (b_start),
        .len        (b_len),
`ifdef WS2812B_BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .busy       (b_busy),
        .done       (b_done),
        .pix_data   (b_pix_data),
        .pix_valid  (b_pix_valid),
        .pix_latch  (b_pix_latch),
        .pix_ready  (b_pix_ready)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [23:0] model_mem [N];
    logic [23:0] model12   [N2];
    logic [23:0] got_q[$];
    logic        lat_q[$];
    int          done_cnt = 0;
    logic [23:0] b_got_q[$];
    logic        b_lat_q[$];
    int          b_done_cnt = 0;

    // Handshakes are observed mid-cycle; they complete on the following rising edge
    always @(negedge clk) begin
        if (!rst) begin
            if (pix_valid && pix_ready) begin
                got_q.push_back(pix_data);
                lat_q.push_back(pix_latch);
            end
            if (done) done_cnt++;
            if (b_pix_valid && b_pix_ready) begin
                b_got_q.push_back(b_pix_data);
                b_lat_q.push_back(b_pix_latch);
            end
            if (b_done) b_done_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] exp_pix(input logic [23:0] p);
`ifdef WS2812B_BRIGHTNESS_EN
        int g, r, b;
        g = ((int'(p) >> 16) & 255) * (int'(brightness) + 1) / 256;
        r = ((int'(p) >> 8) & 255) * (int'(brightness) + 1) / 256;
        b = (int'(p) & 255) * (int'(brightness) + 1) / 256;
        return 24'(g * 65536 + r * 256 + b);
`else
        return p;
`endif
    endfunction

    task automatic write_px(input int a, input logic [23:0] d);
        wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
        tick();
        wr_en = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic set_ready(input bit rnd);
        pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    // Starts a frame, checks the two-cycle start latency, then waits for done
    task automatic start_frame(input string tag, input int l, input bit rnd);
        got_q.delete(); lat_q.delete(); done_cnt = 0;
        len = 5'(l); start = 1'b1; set_ready(rnd);
        tick();
        start = 1'b0;
        chk({tag, "_lat1_valid"}, pix_valid, 0);
        chk({tag, "_lat1_busy"}, busy, 1);
        set_ready(rnd);
        tick();
        chk({tag, "_lat2_valid"}, pix_valid, 1);
    endtask

    task automatic wait_done(input string tag, input bit rnd);
        int cyc = 0;
        while (done_cnt == 0 && cyc < 2000) begin
            set_ready(rnd);
            tick();
            cyc++;
        end
        chk({tag, "_done_seen"}, done_cnt > 0, 1);
        pix_ready = 1'b1;
        repeat (3) tick();
    endtask

    task automatic check_frame(input string tag, input int l);
        int n;
        n = (l > N) ? N : l;
        chk({tag, "_count"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            chk($sformatf("%s_pix%0d", tag, i), got_q[i], exp_pix(model_mem[i]));
            chk($sformatf("%s_latch%0d", tag, i), lat_q[i], (i == n - 1));
        end
        chk({tag, "_done_once"}, done_cnt, 1);
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_valid_after"}, pix_valid, 0);
    endtask

    task automatic run_frame(input string tag, input int l, input bit rnd);
        start_frame(tag, l, rnd);
        wait_done(tag, rnd);
        check_frame(tag, l);
    endtask

    task automatic b_write(input int a, input logic [23:0] d);
        b_wr_en = 1'b1; b_wr_addr = 4'(a); b_wr_data = d;
        tick();
        b_wr_en = 1'b0;
        if (a < N2) model12[a] = d;
    endtask

    task automatic b_run(input string tag);
        int cyc = 0;
        b_got_q.delete(); b_lat_q.delete(); b_done_cnt = 0;
        b_len = 5'(N2); b_start = 1'b1;
        tick();
        b_start = 1'b0;
        while (b_done_cnt == 0 && cyc < 2000) begin
            tick();
            cyc++;
        end
        chk({tag, "_done_seen"}, b_done_cnt > 0, 1);
        chk({tag, "_count"}, b_got_q.size(), N2);
        for (int i = 0; i < N2 && i < b_got_q.size(); i++) begin
            chk($sformatf("%s_pix%0d", tag, i), b_got_q[i], exp_pix(model12[i]));
        end
    endtask

    initial begin
        int l;
        logic [23:0] newv;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; len = '0;
        brightness = 8'hFF; pix_ready = 1'b0;
        b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_start = 1'b0; b_len = '0;
        b_pix_ready = 1'b1;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", pix_valid, 0);
        chk("rst_latch", pix_latch, 0);
        chk("rst_data", pix_data, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < N; i++) write_px(i, 24'($urandom));
        write_px(0, 24'hFF0000);
        write_px(1, 24'h00FF00);
        write_px(2, 24'h0000FF);

        run_frame("basic3", 3, 1'b0);
        chk("basic3_last_is_blue", (got_q.size() == 3) ? got_q[2] : 24'h0, 24'h0000FF);

        // Pixel 1 is stalled for 50 cycles and must stay put
        pix_ready = 1'b1;
        start_frame("stall", 3, 1'b0);
        for (int c = 0; c < 10 && got_q.size() < 1; c++) tick();
        pix_ready = 1'b0;
        tick();
        for (int c = 0; c < 50; c++) begin
            chk("stall_valid", pix_valid, 1);
            chk("stall_data", pix_data, 24'h00FF00);
            chk("stall_latch", pix_latch, 0);
            tick();
        end
        wait_done("stall", 1'b0);
        check_frame("stall", 3);

        // Zero-length start
        got_q.delete(); done_cnt = 0;
        len = 5'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("len0_done", done, 1);
        chk("len0_valid", pix_valid, 0);
        chk("len0_busy", busy, 0);
        tick();
        chk("len0_done_clear", done, 0);
        repeat (4) tick();
        chk("len0_no_pixels", got_q.size(), 0);
        chk("len0_done_cnt", done_cnt, 1);

        run_frame("len20", 20, 1'b1);

        // Restart while busy plus a write to an already-fetched index
        newv = 24'h123456;
        start_frame("midstart", 5, 1'b0);
        for (int c = 0; c < 40 && !(pix_valid && got_q.size() == 2); c++) tick();
        chk("midstart_at_px2", pix_valid && got_q.size() == 2, 1);
        start = 1'b1; len = 5'd1;
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = newv;
        tick();
        start = 1'b0; wr_en = 1'b0;
        wait_done("midstart", 1'b0);
        check_frame("midstart", 5);
        model_mem[2] = newv;
        repeat (5) tick();
        chk("midstart_no_requeue", got_q.size(), 5);
        chk("midstart_idle", busy, 0);

        // Reset in the middle of a frame
        start_frame("rstmid", 16, 1'b1);
        for (int c = 0; c < 200 && got_q.size() < 3; c++) begin
            set_ready(1'b1);
            tick();
        end
        done_cnt = 0;
        rst = 1'b1;
        tick();
        chk("rstmid_valid", pix_valid, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_done", done, 0);
        chk("rstmid_latch", pix_latch, 0);
        rst = 1'b0;
        repeat (5) tick();
        chk("rstmid_no_done", done_cnt, 0);
        chk("rstmid_still_idle", pix_valid, 0);

        run_frame("post_rst", 16, 1'b1);

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N; i++) write_px(i, 24'($urandom));
            l = $urandom_range(1, N);
            run_frame($sformatf("rand%0d", k), l, 1'b1);
        end

`ifdef WS2812B_BRIGHTNESS_EN
        write_px(0, 24'h80FF40);
        brightness = 8'd127;
        run_frame("brt127", 1, 1'b0);
        chk("brt127_exact", (got_q.size() > 0) ? got_q[0] : 24'h0, 24'h407F20);
        brightness = 8'd255;
        run_frame("brt255", 1, 1'b0);
        chk("brt255_exact", (got_q.size() > 0) ? got_q[0] : 24'h0, 24'h80FF40);
        brightness = 8'd0;
        run_frame("brt0", 2, 1'b1);
        brightness = 8'hFF;
`endif

        // Out-of-range writes on the 12-entry instance leave the frame unchanged
        for (int i = 0; i < N2; i++) b_write(i, 24'($urandom));
        b_run("oor_before");
        for (int a = N2; a < 16; a++) b_write(a, 24'($urandom));
        b_run("oor_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
